// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: pipelined barrel shifter/rotator with one mux level per stage.
// A single global stall (advance) moves or holds every stage together.
module shift_rotate_unit #(
  parameter int WIDTH = 32,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  typedef enum logic [2:0] {
    OP_SHL  = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHRA = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100
  } op_e;

  typedef struct packed {
    logic             valid;
    op_e              mode;
    logic [LOG2W-1:0] amt;
    logic             sat;
    logic             fill;
    logic             carry;
    logic             err;
    logic [WIDTH-1:0] data;
  } stage_t;

  localparam logic [WIDTH-1:0] WIDTH_B = WIDTH'(WIDTH);

  logic             advance;
  logic [LOG2W-1:0] n_low;
  logic [LOG2W-1:0] idx_neg;
  logic [LOG2W-1:0] idx_dec;
  logic             n_zero;
  logic             n_ge_w;
  logic             n_gt_w;
  stage_t           acc;
  stage_t           q   [LOG2W-1];
  stage_t           nxt [LOG2W-1];
  logic [WIDTH-1:0] fin_data;
  logic             fin_zero;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // idx_neg = (WIDTH - n) mod WIDTH and idx_dec = (n - 1) mod WIDTH pick the last bit out
  assign n_low   = B[LOG2W-1:0];
  assign idx_neg = '0 - n_low;
  assign idx_dec = n_low - LOG2W'(1);
  assign n_zero  = (B == '0);
  assign n_ge_w  = |B[WIDTH-1:LOG2W];
  assign n_gt_w  = n_ge_w && (B != WIDTH_B);

  // Shift/rotate by 2^k when bit k of the stored amount is set
  function automatic logic [WIDTH-1:0] shift_stage(input stage_t s, input int k);
    logic [WIDTH-1:0] d;
    logic [LOG2W-1:0] sel;
    int               sh;
    sh  = 1 << k;
    sel = LOG2W'(1) << k;
    d   = s.data;
    if (|(s.amt & sel)) begin
      case (s.mode)
        OP_SHL:  d = s.data << sh;
        OP_SHR:  d = s.data >> sh;
        OP_SHRA: d = $signed(s.data) >>> sh;
        OP_ROL:  d = (s.data << sh) | (s.data >> (WIDTH - sh));
        OP_ROR:  d = (s.data >> sh) | (s.data << (WIDTH - sh));
        default: d = s.data;
      endcase
    end
    return d;
  endfunction

  // Illegal ops travel as a zero-amount shift so the data comes out unchanged
  always_comb begin
    acc       = '0;
    acc.valid = in_valid;
    acc.data  = A;
    acc.mode  = OP_SHL;
    case (op)
      OP_SHL: begin
        acc.amt   = n_low;
        acc.sat   = n_ge_w;
        acc.carry = !n_zero && !n_gt_w && A[idx_neg];
      end
      OP_SHR: begin
        acc.mode  = OP_SHR;
        acc.amt   = n_low;
        acc.sat   = n_ge_w;
        acc.carry = !n_zero && !n_gt_w && A[idx_dec];
      end
      OP_SHRA: begin
        acc.mode  = OP_SHRA;
        acc.amt   = n_low;
        acc.sat   = n_ge_w;
        acc.fill  = A[WIDTH-1];
        acc.carry = n_gt_w ? A[WIDTH-1] : (!n_zero && A[idx_dec]);
      end
      OP_ROL: begin
        acc.mode  = OP_ROL;
        acc.amt   = n_low;
        acc.carry = (n_low != '0) && A[idx_neg];
      end
      OP_ROR: begin
        acc.mode  = OP_ROR;
        acc.amt   = n_low;
        acc.carry = (n_low != '0) && A[idx_dec];
      end
      default: acc.err = 1'b1;
    endcase
  end

  always_comb begin
    nxt[0]      = acc;
    nxt[0].data = shift_stage(acc, 0);
    for (int k = 1; k < LOG2W-1; k++) begin
      nxt[k]      = q[k-1];
      nxt[k].data = shift_stage(q[k-1], k);
    end
  end

  // Last mux level also applies the saturation override before the output register
  always_comb begin
    fin_data = shift_stage(q[LOG2W-2], LOG2W-1);
    if (q[LOG2W-2].sat) begin
      fin_data = {WIDTH{q[LOG2W-2].fill}};
    end
  end

  assign fin_zero = (fin_data == '0);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int k = 0; k < LOG2W-1; k++) begin
        q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < LOG2W-1; k++) begin
        q[k] <= nxt[k];
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else if (advance) begin
      out_valid <= q[LOG2W-2].valid;
      result    <= fin_data;
      carry     <= q[LOG2W-2].carry;
      zero      <= fin_zero;
      err       <= q[LOG2W-2].err;
    end
  end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// tb_shift_rotate_unit: table vectors plus random traffic against a scoreboard
// fed by an independent reference model; covers stalls and a mid-flight clear.
module tb_shift_rotate_unit;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        e;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        err;
    bit          check_lat;
    int          acc_cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry;
  logic        zero;
  logic        err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  bit   check_lat = 1'b0;
  bit   rand_phase = 1'b0;
  exp_t pending;
  exp_t exp_q [$];
  exp_t got;
  vec_t vecs [20];

  logic        prev_stall = 1'b0;
  logic [31:0] prev_result;
  logic        prev_carry;
  logic        prev_zero;
  logic        prev_err;

  shift_rotate_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (opnd_a),
    .B         (opnd_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] t;
    int          bb;
    int          k;
    e  = '{default: 0};
    bb = (b > 32'd40) ? 40 : int'(b);
    k  = int'(b[4:0]);
    case (o)
      3'd0: begin t = {1'b0, a} << bb; e.result = t[31:0]; e.carry = t[32]; end
      3'd1: begin t = {a, 1'b0} >> bb; e.result = t[32:1]; e.carry = t[0]; end
      3'd2: begin t = $signed({a, 1'b0}) >>> bb; e.result = t[32:1]; e.carry = t[0]; end
      3'd3: begin
        e.result = (k == 0) ? a : ((a << k) | (a >> (32 - k)));
        e.carry  = (k != 0) && e.result[0];
      end
      3'd4: begin
        e.result = (k == 0) ? a : ((a >> k) | (a << (32 - k)));
        e.carry  = (k != 0) && e.result[31];
      end
      default: begin e.result = a; e.err = 1'b1; end
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Offer one op (caller is aligned just after a rising edge); returns once accepted
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int guard = 0;
    bit taken = 1'b0;
    pending  = e;
    op       = o;
    opnd_a   = a;
    opnd_b   = b;
    in_valid = 1'b1;
    while (!taken && guard < 100) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!taken) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: push on accept, pop on retire, protocol and hold checks every cycle
  always @(negedge clk) begin
    cycle++;
    if (!clr) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      checkOutput("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_result", 64'(result), 64'(prev_result));
        checkOutput("hold_flags", {61'd0, carry, zero, err}, {61'd0, prev_carry, prev_zero, prev_err});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          got = exp_q.pop_front();
          checkOutput("result", 64'(result), 64'(got.result));
          checkOutput("carry", 64'(carry), 64'(got.carry));
          checkOutput("zero", 64'(zero), 64'(got.zero));
          checkOutput("err", 64'(err), 64'(got.err));
          if (got.check_lat) checkOutput("latency", 64'(cycle - got.acc_cycle), 64'd5);
        end
      end
      if (in_valid && in_ready) begin
        pending.acc_cycle = cycle;
        exp_q.push_back(pending);
      end
      prev_stall  = out_valid && !out_ready;
      prev_result = result;
      prev_carry  = carry;
      prev_zero   = zero;
      prev_err    = err;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_phase) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t        e;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{3'd4, 32'h80000001, 32'd1,  32'hC0000000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'd3, 32'h12345678, 32'd0,  32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'd4, 32'h12345678, 32'd36, 32'h81234567, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'd2, 32'h80000000, 32'd40, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'd1, 32'h80000000, 32'd40, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'd0, 32'h00000001, 32'd32, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{3'd5, 32'hDEADBEEF, 32'd3,  32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{3'd0, 32'h000000F1, 32'd4,  32'h00000F10, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 32'h80000001, 32'd1,  32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'd1, 32'h00000003, 32'd1,  32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'd2, 32'h80000010, 32'd4,  32'hF8000001, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'd2, 32'h7FFFFFFF, 32'd32, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'd1, 32'hF0000000, 32'd32, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{3'd3, 32'h80000000, 32'd1,  32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{3'd3, 32'h12345678, 32'd64, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{3'd0, 32'hFFFFFFFF, 32'd33, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{3'd7, 32'h00000000, 32'd5,  32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{3'd2, 32'h80000000, 32'd0,  32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{3'd4, 32'h00000001, 32'd31, 32'h00000002, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{3'd1, 32'h80000000, 32'd31, 32'h00000001, 1'b0, 1'b0, 1'b0};

    clr       = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    opnd_a    = 32'd0;
    opnd_b    = 32'd0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_flags", {61'd0, carry, zero, err}, 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    #3 clr = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] table vectors, back-to-back, no stalls");
    for (int i = 0; i < 20; i++) begin
      e = '{vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].e, 1'b1, 0};
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, e);
    end
    in_valid = 1'b0;
    drain();

    $display("[TB] random ops with random back-pressure");
    rand_phase = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      applyStimulus(ro, ra, rb, model(ro, ra, rb));
    end
    in_valid = 1'b0;
    drain();
    rand_phase = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] clear with three ops in flight");
    applyStimulus(3'd3, 32'h0000000F, 32'd4, model(3'd3, 32'h0000000F, 32'd4));
    applyStimulus(3'd0, 32'h00000001, 32'd8, model(3'd0, 32'h00000001, 32'd8));
    applyStimulus(3'd1, 32'hFF000000, 32'd8, model(3'd1, 32'hFF000000, 32'd8));
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("pre_clr_valid", 64'(out_valid), 64'd1);
    clr = 1'b0;
    #1;
    checkOutput("clr_out_valid", 64'(out_valid), 64'd0);
    checkOutput("clr_result", 64'(result), 64'd0);
    checkOutput("clr_flags", {61'd0, carry, zero, err}, 64'd0);
    @(posedge clk);
    #3 clr = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_lat = 1'b1;
    e = '{32'hC0000000, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    applyStimulus(3'd4, 32'h80000001, 32'd1, e);
    in_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_rotate_unit.md
# shift_rotate_unit

Parametrised, pipelined shift/rotate unit for the ALU. It supports logical left/right shift, arithmetic right shift, and left/right rotate on a WIDTH-bit operand. The shift amount is carried on a full WIDTH-bit port and well-defined for every value, including 0 and values ≥ WIDTH. The unit sits beside the other ALU operators behind a valid/ready handshake, so the datapath controller can issue one operation per cycle and stall on back-pressure.

## Interface
- WIDTH, 32, operand width; power of two, 8..64
- LOG2W, $clog2(WIDTH), number of mux levels, which is also the pipeline depth
- clk  input  1  clock; all registers update on the rising edge
- clr  input  1  reset, asynchronous, active-low
- in_valid  input  1  operation offered
- in_ready  output  1  unit accepts this cycle
- op  input  3  000 SHL, 001 SHR (logical), 010 SHRA, 011 ROL, 100 ROR; 101..111 illegal
- A  input  WIDTH  data operand
- B  input  WIDTH  shift/rotate amount, unsigned
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  shifted/rotated value
- carry  output  1  last bit shifted out
- zero  output  1  result == 0
- err  output  1  op was illegal

## Operation
- Amount rules (n = B):
  - Rotates use n mod WIDTH.
  - SHL/SHR with n ≥ WIDTH → result 0.
  - SHRA with n ≥ WIDTH → all bits = A[WIDTH-1].
  - n = 0 → result = A for every legal op.
- Carry rules:
  - SHL, 1 ≤ n ≤ WIDTH → A[WIDTH-n]. SHR/SHRA, 1 ≤ n ≤ WIDTH → A[n-1].
  - n > WIDTH → 0 for SHL/SHR; A[WIDTH-1] for SHRA.
  - ROL → result[0]; ROR → result[WIDTH-1]. Both apply only when n mod WIDTH ≠ 0.
  - n = 0, or rotate with n mod WIDTH = 0 → carry 0.
- Illegal op → result = A, carry 0, err 1. zero still reflects result.
- Structure:
  - Saturation flag, carry, and err are decoded combinationally at acceptance and travel down the pipe with the data.
  - Stage k (0..LOG2W-1) conditionally shifts/rotates by 2^k according to bit k of n mod WIDTH.
  - Each stage has a pipeline register; the saturation override is applied in the last stage.
- zero is computed from the final result before the output register.
- Reset: all valid bits, result, carry, zero, and err = 0. Asserting clr mid-operation flushes every in-flight operation immediately, with no partial output after release.

## Timing
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - Transfer occurs when in_valid && in_ready.
- When advance = 1, every stage moves forward one position; when advance = 0, every stage holds.
- Latency: result appears with out_valid exactly LOG2W cycles after acceptance (5 for WIDTH = 32) when there are no stalls.
- Throughput: one operation per cycle while out_ready = 1.
- Operations leave in acceptance order; none are lost or duplicated.
- While out_valid = 1 and out_ready = 0, result/carry/zero/err are stable.
- Bubbles (in_valid = 0) travel through as invalid slots. out_valid may drop between results.
- Simultaneous accept at the input and retire at the output in the same cycle is legal.
- All outputs are registered except in_ready.

## Test plan
- WIDTH = 32, ROR, A = 0x80000001, B = 1 → result 0xC0000000, carry 1, out_valid exactly 5 cycles after accept.
- ROL A = 0x12345678, B = 0 → 0x12345678, carry 0. ROR same A, B = 36 → 0x81234567, carry 1.
- A = 0x80000000, B = 40:
  - SHRA → 0xFFFFFFFF, carry 1.
  - SHR → 0, zero 1, carry 0.
- SHL A = 1, B = 32 → 0, carry 1, zero 1.
- 16 random back-to-back ops with out_ready randomly toggled → results match the reference model in order. in_ready is low exactly when out_valid && !out_ready, and outputs are held while stalled.
- 3 ops in flight, clr pulsed low mid-cycle → out_valid, result, and flags read 0 immediately. After release, no stale result emerges, and the next op returns correctly after 5 cycles.
- op = 101, A = 0xDEADBEEF → result 0xDEADBEEF, err 1, carry 0, zero 0.
